// File: rtl/atomic_bus_initiator_pkg.sv
// Shared definitions for the RV32A bus initiator: funct5 op codes, bus tag
// encodings, the controller state enum and small decode helpers.
package atomic_bus_initiator_pkg;

  // funct5 field of the A-extension instructions
  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SWAP = 5'b00001;
  localparam logic [4:0] OP_LR   = 5'b00010;
  localparam logic [4:0] OP_SC   = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_OR   = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01100;
  localparam logic [4:0] OP_MIN  = 5'b10000;
  localparam logic [4:0] OP_MAX  = 5'b10100;
  localparam logic [4:0] OP_MINU = 5'b11000;
  localparam logic [4:0] OP_MAXU = 5'b11100;

  // Address tag: {mode[1:0], lock}. Responders use it to track reservations.
  localparam logic [1:0] MODE_NONE = 2'b00;
  localparam logic [1:0] MODE_LRSC = 2'b01;
  localparam logic [1:0] MODE_AMO  = 2'b10;
  localparam logic       TAG_UNLOCK = 1'b0;
  localparam logic       TAG_LOCK   = 1'b1;

  // AMO_GAP is the single idle-strobe cycle between the locked read and
  // the unlocking write of a read-modify-write pair.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LR_RD   = 3'd1,
    ST_SC_WR   = 3'd2,
    ST_AMO_RD  = 3'd3,
    ST_AMO_GAP = 3'd4,
    ST_AMO_WR  = 3'd5,
    ST_DONE    = 3'd6
  } state_e;

  function automatic logic op_is_amo(input logic [4:0] op);
    case (op)
      OP_SWAP, OP_ADD, OP_XOR, OP_AND, OP_OR,
      OP_MIN, OP_MAX, OP_MINU, OP_MAXU: return 1'b1;
      default:                          return 1'b0;
    endcase
  endfunction

  function automatic logic op_is_supported(input logic [4:0] op);
    return op_is_amo(op) || (op == OP_LR) || (op == OP_SC);
  endfunction

  function automatic logic [2:0] bus_tag(input logic [1:0] mode, input logic lock);
    return {mode, lock};
  endfunction

endpackage

// File: rtl/atomic_alu.sv
// Combinational AMO operator: computes the value written back in the second
// half of an AMO read-modify-write from the old memory word and rs2.
module atomic_alu (
  input  logic [4:0]  op_i,
  input  logic [31:0] old_i,
  input  logic [31:0] rs2_i,
  output logic [31:0] new_o
);
  import atomic_bus_initiator_pkg::*;

  logic signed [31:0] w_old_s;
  logic signed [31:0] w_rs2_s;

  assign w_old_s = old_i;
  assign w_rs2_s = rs2_i;

  // Select the AMO result; non-AMO codes never reach the write phase
  always_comb begin
    new_o = rs2_i;
    case (op_i)
      OP_SWAP: new_o = rs2_i;
      OP_ADD:  new_o = old_i + rs2_i;
      OP_XOR:  new_o = old_i ^ rs2_i;
      OP_AND:  new_o = old_i & rs2_i;
      OP_OR:   new_o = old_i | rs2_i;
      OP_MIN:  new_o = (w_old_s < w_rs2_s) ? old_i : rs2_i;
      OP_MAX:  new_o = (w_old_s > w_rs2_s) ? old_i : rs2_i;
      OP_MINU: new_o = (old_i < rs2_i) ? old_i : rs2_i;
      OP_MAXU: new_o = (old_i > rs2_i) ? old_i : rs2_i;
      default: new_o = rs2_i;
    endcase
  end

endmodule

// File: rtl/atomic_bus_initiator.sv
// Wishbone initiator for RV32A lr.w / sc.w / amo*.w. Drives the reservation
// tag, runs AMOs as a locked read followed by an unlocking write, and returns
// rd with a one-cycle done pulse. All bus outputs come straight from flops.
// TIMEOUT_CYCLES must be at least 2.
module atomic_bus_initiator #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_i,
  input  logic [4:0]  op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] rs2_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic        err_o,
  output logic        stb_o,
  output logic        cyc_o,
  output logic [31:0] addr_o,
  output logic [2:0]  addr_tag_o,
  output logic [31:0] data_o,
  output logic [3:0]  sel_o,
  output logic        we_o,
  input  logic        ack_i,
  input  logic        err_i,
  input  logic [31:0] data_i,
  input  logic        data_tag_i
);
  import atomic_bus_initiator_pkg::*;

  localparam int              TMO_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_e            r_state;
  state_e            w_state_nxt;

  logic              r_stb,    w_stb_nxt;
  logic              r_cyc,    w_cyc_nxt;
  logic              r_we,     w_we_nxt;
  logic              r_done,   w_done_nxt;
  logic              r_err,    w_err_nxt;
  logic [31:0]       r_addr,   w_addr_nxt;
  logic [2:0]        r_tag,    w_tag_nxt;
  logic [31:0]       r_data,   w_data_nxt;
  logic [31:0]       r_result, w_result_nxt;
  logic [31:0]       r_old,    w_old_nxt;
  logic [31:0]       r_rs2,    w_rs2_nxt;
  logic [4:0]        r_op,     w_op_nxt;
  logic [TMO_W-1:0]  r_tmo,    w_tmo_nxt;

  logic              w_bad_req;
  logic              w_abort;
  logic              w_ack;
  logic [31:0]       w_alu_new;

  // Misaligned or non-A requests complete immediately with an error
  assign w_bad_req = (addr_i[1:0] != 2'b00) || !op_is_supported(op_i);

  // Responses only count while the strobe is up; err_i and timeout beat ack
  assign w_abort = r_stb && (err_i || (r_tmo == TMO_LAST));
  assign w_ack   = r_stb && ack_i;

  atomic_alu u_alu (
    .op_i  (r_op),
    .old_i (r_old),
    .rs2_i (r_rs2),
    .new_o (w_alu_new)
  );

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req_i) begin
          if (w_bad_req)           w_state_nxt = ST_DONE;
          else if (op_i == OP_LR)  w_state_nxt = ST_LR_RD;
          else if (op_i == OP_SC)  w_state_nxt = ST_SC_WR;
          else                     w_state_nxt = ST_AMO_RD;
        end
      end
      ST_LR_RD, ST_SC_WR, ST_AMO_WR: begin
        if (w_abort || w_ack) w_state_nxt = ST_DONE;
      end
      ST_AMO_RD: begin
        if (w_abort)    w_state_nxt = ST_DONE;
        else if (w_ack) w_state_nxt = ST_AMO_GAP;
      end
      ST_AMO_GAP: w_state_nxt = ST_AMO_WR;
      ST_DONE:    w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered bus outputs, result and working registers
  always_comb begin
    w_stb_nxt    = r_stb;
    w_cyc_nxt    = r_cyc;
    w_we_nxt     = r_we;
    w_addr_nxt   = r_addr;
    w_tag_nxt    = r_tag;
    w_data_nxt   = r_data;
    w_done_nxt   = 1'b0;
    w_err_nxt    = 1'b0;
    w_result_nxt = r_result;
    w_old_nxt    = r_old;
    w_rs2_nxt    = r_rs2;
    w_op_nxt     = r_op;
    w_tmo_nxt    = r_tmo;
    case (r_state)
      ST_IDLE: begin
        if (req_i) begin
          w_op_nxt  = op_i;
          w_rs2_nxt = rs2_i;
          w_tmo_nxt = '0;
          if (w_bad_req) begin
            w_done_nxt   = 1'b1;
            w_err_nxt    = 1'b1;
            w_result_nxt = '0;
          end else begin
            w_stb_nxt  = 1'b1;
            w_cyc_nxt  = 1'b1;
            w_addr_nxt = addr_i;
            w_we_nxt   = (op_i == OP_SC);
            w_data_nxt = (op_i == OP_SC) ? rs2_i : '0;
            if (op_i == OP_LR)      w_tag_nxt = bus_tag(MODE_LRSC, TAG_LOCK);
            else if (op_i == OP_SC) w_tag_nxt = bus_tag(MODE_LRSC, TAG_UNLOCK);
            else                    w_tag_nxt = bus_tag(MODE_AMO, TAG_LOCK);
          end
        end
      end
      ST_LR_RD, ST_SC_WR, ST_AMO_RD, ST_AMO_WR: begin
        if (w_abort) begin
          // An aborted AMO read took no lock, so no unlock write follows
          w_stb_nxt    = 1'b0;
          w_cyc_nxt    = 1'b0;
          w_we_nxt     = 1'b0;
          w_tag_nxt    = bus_tag(MODE_NONE, TAG_UNLOCK);
          w_done_nxt   = 1'b1;
          w_err_nxt    = 1'b1;
          w_result_nxt = '0;
        end else if (w_ack) begin
          if (r_state == ST_AMO_RD) begin
            // Keep cyc_o and the lock tag; strobe rests for one cycle
            w_old_nxt = data_i;
            w_stb_nxt = 1'b0;
          end else begin
            w_stb_nxt  = 1'b0;
            w_cyc_nxt  = 1'b0;
            w_we_nxt   = 1'b0;
            w_tag_nxt  = bus_tag(MODE_NONE, TAG_UNLOCK);
            w_done_nxt = 1'b1;
            if (r_state == ST_LR_RD)      w_result_nxt = data_i;
            else if (r_state == ST_SC_WR) w_result_nxt = {31'b0, data_tag_i};
            else                          w_result_nxt = r_old;
          end
        end else begin
          w_tmo_nxt = r_tmo + 1'b1;
        end
      end
      ST_AMO_GAP: begin
        w_stb_nxt  = 1'b1;
        w_we_nxt   = 1'b1;
        w_tag_nxt  = bus_tag(MODE_AMO, TAG_UNLOCK);
        w_data_nxt = w_alu_new;
        w_tmo_nxt  = '0;
      end
      default: ;
    endcase
  end

  // Output and working registers; reset mid-transfer drops the bus at once
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_stb    <= 1'b0;
      r_cyc    <= 1'b0;
      r_we     <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_addr   <= '0;
      r_tag    <= bus_tag(MODE_NONE, TAG_UNLOCK);
      r_data   <= '0;
      r_result <= '0;
      r_old    <= '0;
      r_rs2    <= '0;
      r_op     <= '0;
      r_tmo    <= '0;
    end else begin
      r_stb    <= w_stb_nxt;
      r_cyc    <= w_cyc_nxt;
      r_we     <= w_we_nxt;
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
      r_addr   <= w_addr_nxt;
      r_tag    <= w_tag_nxt;
      r_data   <= w_data_nxt;
      r_result <= w_result_nxt;
      r_old    <= w_old_nxt;
      r_rs2    <= w_rs2_nxt;
      r_op     <= w_op_nxt;
      r_tmo    <= w_tmo_nxt;
    end
  end

  assign stb_o      = r_stb;
  assign cyc_o      = r_cyc;
  assign we_o       = r_we;
  assign addr_o     = r_addr;
  assign addr_tag_o = r_tag;
  assign data_o     = r_data;
  assign sel_o      = 4'hF;
  assign done_o     = r_done;
  assign err_o      = r_err;
  assign result_o   = r_result;
  assign busy_o     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_atomic_bus_initiator.sv
// Directed bench for atomic_bus_initiator: a vector table of complete
// transactions driven through a small responder model, plus hand-written
// sequences for timeout, bus error, busy-request and mid-phase reset.
module tb_atomic_bus_initiator;
  import atomic_bus_initiator_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        req_i;
  logic [4:0]  op_i;
  logic [31:0] addr_i;
  logic [31:0] rs2_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;
  logic        err_o;
  logic        stb_o;
  logic        cyc_o;
  logic [31:0] addr_o;
  logic [2:0]  addr_tag_o;
  logic [31:0] data_o;
  logic [3:0]  sel_o;
  logic        we_o;
  logic        ack_i;
  logic        err_i;
  logic [31:0] data_i;
  logic        data_tag_i;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  atomic_bus_initiator #(.TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .req_i(req_i), .op_i(op_i),
    .addr_i(addr_i), .rs2_i(rs2_i), .busy_o(busy_o), .done_o(done_o),
    .result_o(result_o), .err_o(err_o), .stb_o(stb_o), .cyc_o(cyc_o),
    .addr_o(addr_o), .addr_tag_o(addr_tag_o), .data_o(data_o), .sel_o(sel_o),
    .we_o(we_o), .ack_i(ack_i), .err_i(err_i), .data_i(data_i),
    .data_tag_i(data_tag_i)
  );

  typedef struct {
    logic [4:0]  op;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [31:0] rdata;   // read data / old value returned on first ack
    logic        dtag;
    int          nphase;  // bus phases expected (0 = rejected up front)
    logic [2:0]  tag0;
    logic [2:0]  tag1;
    logic        we0;
    logic [31:0] wdata;   // expected write data (SC phase or AMO write phase)
    logic [31:0] res;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%08h required=%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [4:0] op, input logic [31:0] addr,
                              input logic [31:0] rs2, input logic [31:0] rdata,
                              input logic dtag, input int nphase,
                              input logic [2:0] tag0, input logic [2:0] tag1,
                              input logic we0, input logic [31:0] wdata,
                              input logic [31:0] res, input logic err);
    vec_t v;
    v.op = op; v.addr = addr; v.rs2 = rs2; v.rdata = rdata; v.dtag = dtag;
    v.nphase = nphase; v.tag0 = tag0; v.tag1 = tag1; v.we0 = we0;
    v.wdata = wdata; v.res = res; v.err = err;
    return v;
  endfunction

  task automatic clear_bus_inputs();
    ack_i = 1'b0; err_i = 1'b0; data_i = 32'h0; data_tag_i = 1'b0;
  endtask

  // Issue one request and act as a responder that acks on the second strobe cycle
  task automatic run_vec(input vec_t v, input int idx);
    int  phase = 0;
    int  wcnt  = 0;
    int  gap   = 0;
    int  iter;
    bit  done_seen = 0;
    bit  saw_stb   = 0;
    @(negedge clk_i);
    req_i = 1'b1; op_i = v.op; addr_i = v.addr; rs2_i = v.rs2;
    @(negedge clk_i);
    // Scramble request inputs so any late sampling shows up
    req_i = 1'b0; op_i = 5'b11111; addr_i = 32'hFFFF_FFFC; rs2_i = 32'hA5A5_A5A5;
    for (iter = 0; iter < 64 && !done_seen; iter++) begin
      clear_bus_inputs();
      if (done_o) begin
        done_seen = 1;
        check($sformatf("v%0d.result", idx), result_o, v.res);
        check($sformatf("v%0d.err", idx), err_o, v.err);
        check($sformatf("v%0d.phases", idx), phase, v.nphase);
        check($sformatf("v%0d.cyc_at_done", idx), cyc_o, 1'b0);
        if (v.nphase == 0) begin
          check($sformatf("v%0d.no_stb", idx), saw_stb, 1'b0);
          check($sformatf("v%0d.latency", idx), iter, 0);
        end
      end else begin
        if (stb_o) begin
          saw_stb = 1;
          wcnt++;
          if (wcnt == 1) begin
            check($sformatf("v%0d.busy", idx), busy_o, 1'b1);
            check($sformatf("v%0d.cyc", idx), cyc_o, 1'b1);
            check($sformatf("v%0d.addr", idx), addr_o, v.addr);
            check($sformatf("v%0d.sel", idx), sel_o, 4'hF);
            if (phase == 0) begin
              check($sformatf("v%0d.tag0", idx), addr_tag_o, v.tag0);
              check($sformatf("v%0d.we0", idx), we_o, v.we0);
              if (v.we0) check($sformatf("v%0d.wdata0", idx), data_o, v.wdata);
            end else begin
              check($sformatf("v%0d.gap", idx), gap, 1);
              check($sformatf("v%0d.tag1", idx), addr_tag_o, v.tag1);
              check($sformatf("v%0d.we1", idx), we_o, 1'b1);
              check($sformatf("v%0d.wdata1", idx), data_o, v.wdata);
            end
          end
          if (wcnt == 2) begin
            ack_i = 1'b1; data_i = v.rdata; data_tag_i = v.dtag;
            phase++;
            wcnt = 0;
          end
        end else if (phase == 1 && cyc_o) begin
          // Strobe rest between AMO halves: a stray ack here must be ignored
          gap++;
          ack_i = 1'b1; data_i = 32'hBAD0_BAD0;
        end
        @(negedge clk_i);
      end
    end
    clear_bus_inputs();
    if (!done_seen) check($sformatf("v%0d.done_seen", idx), 0, 1);
    @(negedge clk_i);
    check($sformatf("v%0d.done_pulse", idx), done_o, 1'b0);
    check($sformatf("v%0d.busy_after", idx), busy_o, 1'b0);
  endtask

  initial begin
    int  cnt;
    bit  done_seen;
    bit  any_stb;

    // op, addr, rs2, rdata, dtag, nphase, tag0, tag1, we0, wdata, res, err
    vecs.push_back(mk(OP_LR,   32'h0200_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 1, 3'b011, 3'b000, 1'b0, 32'h0,         32'hDEAD_BEEF, 1'b0));
    vecs.push_back(mk(OP_SC,   32'h0200_0010, 32'h0000_1234, 32'h0,         1'b0, 1, 3'b010, 3'b000, 1'b1, 32'h0000_1234, 32'h0,         1'b0));
    vecs.push_back(mk(OP_SC,   32'h0200_0010, 32'h0000_1234, 32'h0,         1'b1, 1, 3'b010, 3'b000, 1'b1, 32'h0000_1234, 32'h1,         1'b0));
    vecs.push_back(mk(OP_ADD,  32'h0200_0020, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, 2, 3'b101, 3'b100, 1'b0, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0));
    vecs.push_back(mk(OP_MIN,  32'h0200_0024, 32'h0000_0001, 32'h8000_0000, 1'b0, 2, 3'b101, 3'b100, 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0));
    vecs.push_back(mk(OP_MINU, 32'h0200_0024, 32'h0000_0001, 32'h8000_0000, 1'b0, 2, 3'b101, 3'b100, 1'b0, 32'h0000_0001, 32'h8000_0000, 1'b0));
    vecs.push_back(mk(OP_MAX,  32'h0200_0028, 32'h0000_0001, 32'h8000_0000, 1'b0, 2, 3'b101, 3'b100, 1'b0, 32'h0000_0001, 32'h8000_0000, 1'b0));
    vecs.push_back(mk(OP_MAXU, 32'h0200_0028, 32'h0000_0001, 32'h8000_0000, 1'b0, 2, 3'b101, 3'b100, 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0));
    vecs.push_back(mk(OP_XOR,  32'h0200_0030, 32'hFF00_FF00, 32'hF0F0_F0F0, 1'b0, 2, 3'b101, 3'b100, 1'b0, 32'h0FF0_0FF0, 32'hF0F0_F0F0, 1'b0));
    vecs.push_back(mk(OP_AND,  32'h0200_0030, 32'hFF00_FF00, 32'hF0F0_F0F0, 1'b0, 2, 3'b101, 3'b100, 1'b0, 32'hF000_F000, 32'hF0F0_F0F0, 1'b0));
    vecs.push_back(mk(OP_OR,   32'h0200_0030, 32'hFF00_FF00, 32'hF0F0_F0F0, 1'b0, 2, 3'b101, 3'b100, 1'b0, 32'hFFF0_FFF0, 32'hF0F0_F0F0, 1'b0));
    vecs.push_back(mk(OP_SWAP, 32'h0200_0040, 32'hCAFE_F00D, 32'h1111_1111, 1'b0, 2, 3'b101, 3'b100, 1'b0, 32'hCAFE_F00D, 32'h1111_1111, 1'b0));
    vecs.push_back(mk(OP_SWAP, 32'h0200_0042, 32'hCAFE_F00D, 32'h0,         1'b0, 0, 3'b000, 3'b000, 1'b0, 32'h0,         32'h0,         1'b1));
    vecs.push_back(mk(5'b00101, 32'h0200_0044, 32'h0,        32'h0,         1'b0, 0, 3'b000, 3'b000, 1'b0, 32'h0,         32'h0,         1'b1));

    rst_n_i = 1'b0; req_i = 1'b0; op_i = 5'b0; addr_i = 32'h0; rs2_i = 32'h0;
    clear_bus_inputs();
    repeat (2) @(negedge clk_i);
    check("rst.stb", stb_o, 1'b0);
    check("rst.cyc", cyc_o, 1'b0);
    check("rst.we", we_o, 1'b0);
    check("rst.done", done_o, 1'b0);
    check("rst.err", err_o, 1'b0);
    check("rst.busy", busy_o, 1'b0);
    check("rst.addr", addr_o, 32'h0);
    check("rst.tag", addr_tag_o, 3'b000);
    check("rst.data", data_o, 32'h0);
    check("rst.result", result_o, 32'h0);
    rst_n_i = 1'b1;
    @(negedge clk_i);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Unacked AMO read: strobe held 16 cycles, then error; a request
    // arriving while busy must not start anything
    @(negedge clk_i);
    req_i = 1'b1; op_i = OP_SWAP; addr_i = 32'h0000_0100; rs2_i = 32'h7;
    @(negedge clk_i);
    req_i = 1'b0;
    cnt = 0; done_seen = 0;
    for (int i = 0; i < 40 && !done_seen; i++) begin
      if (done_o) begin
        done_seen = 1;
        check("tmo.stb_cycles", cnt, 16);
        check("tmo.err", err_o, 1'b1);
        check("tmo.result", result_o, 32'h0);
        check("tmo.cyc", cyc_o, 1'b0);
      end else begin
        if (stb_o) begin
          cnt++;
          if (cnt == 10) check("tmo.tag_held", addr_tag_o, 3'b101);
        end
        req_i = (i == 5); op_i = OP_LR; addr_i = 32'h0000_0200;
        @(negedge clk_i);
      end
    end
    req_i = 1'b0;
    if (!done_seen) check("tmo.done_seen", 0, 1);
    any_stb = 0;
    repeat (4) begin
      @(negedge clk_i);
      if (stb_o || cyc_o) any_stb = 1;
    end
    check("tmo.no_followup", any_stb, 1'b0);

    // err_i together with ack_i during the AMO read: error wins, no unlock write
    req_i = 1'b1; op_i = OP_ADD; addr_i = 32'h0000_0300; rs2_i = 32'h5;
    @(negedge clk_i);
    req_i = 1'b0;
    cnt = 0;
    while (!stb_o && cnt < 10) begin
      cnt++;
      @(negedge clk_i);
    end
    check("berr.stb_seen", stb_o, 1'b1);
    err_i = 1'b1; ack_i = 1'b1; data_i = 32'h0000_0123;
    @(negedge clk_i);
    clear_bus_inputs();
    check("berr.done", done_o, 1'b1);
    check("berr.err", err_o, 1'b1);
    check("berr.result", result_o, 32'h0);
    check("berr.cyc", cyc_o, 1'b0);
    any_stb = 0;
    repeat (4) begin
      @(negedge clk_i);
      if (stb_o || cyc_o) any_stb = 1;
    end
    check("berr.no_unlock", any_stb, 1'b0);

    // Reset in the middle of an LR phase drops the bus without a clock edge
    req_i = 1'b1; op_i = OP_LR; addr_i = 32'h0000_0400; rs2_i = 32'h0;
    @(negedge clk_i);
    req_i = 1'b0;
    check("rstmid.stb_before", stb_o, 1'b1);
    #2 rst_n_i = 1'b0;
    #1;
    check("rstmid.cyc", cyc_o, 1'b0);
    check("rstmid.stb", stb_o, 1'b0);
    check("rstmid.tag", addr_tag_o, 3'b000);
    check("rstmid.busy", busy_o, 1'b0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    run_vec(vecs[0], 99);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/atomic_bus_initiator.md
Name: atomic_bus_initiator

Overview:
- Wishbone master in the core memory stage that executes RV32A instructions (lr.w, sc.w, amo*.w) against the IO/memory buses.
- Drives the address tag (mode plus lock/unlock) that bus responders use to track reservations.
- Reads the SC result from `data_tag_i` and performs the AMO read-modify-write as a locked pair of bus cycles.
- Returns the rd value to the pipeline with a single-cycle done pulse.

Parameters:
- TIMEOUT_CYCLES, 1024, cycles without ack/err before a bus phase is aborted with `err_o`; must be ≥ 2.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous, active-low reset
- req_i  in  1  start pulse from pipeline; sampled only in IDLE
- op_i  in  5  funct5 of the A-extension instruction
- addr_i  in  32  effective address
- rs2_i  in  32  store/operand data
- busy_o  out  1  high from the cycle after an accepted req_i until done_o
- done_o  out  1  one-cycle completion pulse
- result_o  out  32  rd value; valid when done_o is high
- err_o  out  1  with done_o: misaligned address, bus error, or timeout
- stb_o  out  1  Wishbone strobe
- cyc_o  out  1  Wishbone cycle
- addr_o  out  32  bus address
- addr_tag_o  out  3  {mode[1:0], lock/unlock} tag
- data_o  out  32  write data
- sel_o  out  4  byte select; always 4'hF
- we_o  out  1  write enable
- ack_i  in  1  responder ack
- err_i  in  1  responder error
- data_i  in  32  read data
- data_tag_i  in  1  on sc.w ack: 1 means reservation invalid (store not performed)

Behaviour:
- Reset (async on rst_n_i low): state IDLE; all outputs 0 (`addr_tag_o` = MODE_NONE, `addr_o` = 0); timeout counter 0. Reset mid-transaction drops cyc_o/stb_o immediately, with no unlock cycle.
- All bus outputs are registered.
- req_i with addr_i[1:0] != 0: no bus cycle; next cycle done_o=1, err_o=1, result_o=0.
- req_i with an unsupported op_i: same response as misaligned.
- States and transitions:
  - IDLE --req_i--> one of LR_RD, SC_WR, AMO_RD; stb_o/cyc_o rise the cycle after req_i.
  - LR_RD: we_o=0, tag {LRSC, LOCK}. On ack: result_o=data_i → DONE.
  - SC_WR: we_o=1, data_o=rs2_i, tag {LRSC, UNLOCK}. On ack: result_o = {31'b0, data_tag_i} → DONE.
  - AMO_RD: we_o=0, tag {AMO, LOCK}. On ack: latch old=data_i, drop stb_o for exactly one cycle (cyc_o stays high) → AMO_WR.
  - AMO_WR: we_o=1, tag {AMO, UNLOCK}, data_o = f(op, old, rs2_i). On ack: result_o=old → DONE.
  - DONE: cyc_o=stb_o=0, done_o=1 for one cycle → IDLE.
- AMO function f:
  - swap → rs2
  - add → 32-bit wrap-around sum
  - xor / and / or → bitwise
  - min / max → signed compare
  - minu / maxu → unsigned compare
- Responder stalls (AMO lock on a held address, gated strobe) appear as a missing ack. The initiator holds stb_o, cyc_o, address, tag and data stable until ack_i, err_i or timeout.
- err_i in any bus state: drop cyc_o/stb_o → DONE with err_o=1, result_o=0. err_i in AMO_RD means no lock was taken, so no unlock write is issued.
- Timeout: counter clears at each phase start and counts while stb_o is high. Reaching TIMEOUT_CYCLES-1 with no ack/err aborts the phase exactly like err_i.
- ack_i and err_i in the same cycle: err_i wins.
- req_i while busy_o=1 is ignored.
- ack_i seen while stb_o=0 is ignored.

Decomposition:
- Shared package/header holds:
  - funct5 op codes (LR=00010, SC=00011, SWAP=00001, ADD=00000, XOR=00100, AND=01100, OR=01000, MIN=10000, MAX=10100, MINU=11000, MAXU=11100)
  - the state enum
- Tag encodings come from the existing shared tags header macros.
- One combinational sub-module, atomic_alu(op, old, rs2) → new value.

Test Plan:
- lr.w @0x0200_0010, responder acks 2 cycles after stb with data 0xDEAD_BEEF → tag {LRSC, LOCK}, we_o=0; done_o with result_o=0xDEAD_BEEF, err_o=0.
- sc.w @0x0200_0010, rs2=0x1234; ack with data_tag_i=0, then repeat with data_tag_i=1 → data_o=0x1234 and tag {LRSC, UNLOCK} in both; result_o=0 then 1.
- amoadd.w, old=0xFFFF_FFFF, rs2=2 → read tag {AMO, LOCK}; stb_o low exactly one cycle between phases with cyc_o high; write data 0x0000_0001 with tag {AMO, UNLOCK}; result_o=0xFFFF_FFFF.
- amomin.w vs amominu.w, old=0x8000_0000, rs2=1 → written values 0x8000_0000 and 0x0000_0001 respectively.
- Misaligned amoswap.w @0x...02 → no stb_o ever; done_o one cycle after req_i with err_o=1.
- AMO_RD never acked, TIMEOUT_CYCLES=16 → stb_o held for 16 cycles, then dropped; done_o with err_o=1. Separately, asserting rst_n_i mid-phase clears cyc_o immediately.
